uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Byte FIFO and launch controller directly upstream of the serial transmitter.
- Accepts bytes from a producer, buffers them, and hands them one at a time to the transmitter over its start/finish handshake.
- Keeps the serial line busy back-to-back while data is queued.
- Same one-clock-per-bit clk domain as the transmitter.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
AW, $clog2(DEPTH), pointer width (derived, not overridable)

Ports:
clk  input  1  bit-rate clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  producer write strobe, one byte per cycle
wr_data  input  8  producer byte
full  output  1  level == DEPTH
empty  output  1  level == 0
level  output  AW+1  bytes stored, 0..DEPTH
overflow  output  1  sticky: a write was dropped
ovf_clr  input  1  clears overflow
tx_start  output  1  one-cycle launch pulse to transmitter
tx_data  output  8  byte for transmitter, valid with tx_start
tx_finish  input  1  transmitter idle/done level

Behaviour:
- Reset (async, rst_n=0):
  - full=0, empty=1, level=0, overflow=0, tx_start=0, tx_data=8'h00.
  - Pointers=0, state=S_IDLE.
  - Stored contents are discarded.
- All outputs registered; full/empty derive from the registered level.
- Write:
  - wr_en=1 with full=0 stores wr_data at wptr, wptr+1 mod DEPTH.
  - wr_en=1 with full=1: byte dropped, overflow<=1. A same-cycle pop does not rescue the write.
- overflow:
  - Cleared by ovf_clr=1.
  - If ovf_clr and a dropped write coincide, set wins.
- level updates each edge: +1 on accepted write, -1 on pop, unchanged when both occur.
- Pointers wrap naturally; level distinguishes full from empty.
- Transmitter contract:
  - tx_finish is 0 out of reset, 1 whenever the transmitter is idle.
  - tx_finish drops the edge after it samples tx_start=1.
  - tx_finish rises again in the stop-bit cycle.
  - tx_data must be stable while tx_start=1.
- FSM:
  - S_IDLE:
    - If empty=0 and tx_finish=1: tx_start<=1, tx_data<=mem[rptr], rptr+1 (pop), go S_LAUNCH.
    - Otherwise tx_start<=0.
  - S_LAUNCH: tx_start<=0, go S_BUSY.
  - S_BUSY:
    - Wait for tx_finish=0 (transmitter accepted).
    - Then go S_DONE.
  - S_DONE: wait for tx_finish=1, then go S_IDLE.
  - The finish low->high sequence is mandatory. It prevents a second launch while tx_finish still reads a stale 1 in the cycle after start.
- Latency:
  - Write at edge E into an empty FIFO, with the transmitter idle: tx_start high from edge E+1 to E+2.
  - The transmitter samples it at E+2.
- Throughput: one byte per transmitter frame. Launch occurs the cycle after tx_finish returns high; one extra idle (mark) cycle per byte is acceptable.
- tx_data holds its last launched value between launches.
- Reset mid-transmission: everything returns to reset values immediately. tx_start is never left asserted.

Decomposition:
- Shared package uart_pkg:
  - State encoding (S_IDLE, S_LAUNCH, S_BUSY, S_DONE).
  - UART_DATA_W=8.
  - Frame length constant UART_FRAME_BITS=10, used by benches.
- One sub-module: uart_sync_fifo (DEPTH, width 8).
  - Contains storage, pointers, level/full/empty and overflow.
  - Has a pop port with read data from the current head.
- uart_tx_feeder instantiates it plus the launch FSM.

Test Plan:
- Single byte: reset, write 8'hA5 (FIFO empty, transmitter idle) -> tx_start one cycle at E+1 with tx_data=8'hA5, level returns to 0; serial pin shows 0,1,0,1,0,0,1,0,1,1 (LSB first, stop).
- Back-to-back: write 8'h01, 8'h02, 8'h03 on consecutive cycles -> exactly three tx_start pulses in order 01,02,03; each pulse only after tx_finish low->high; level peaks at 2 or 3, ends at 0.
- Overflow: DEPTH=4, tx_finish held 0, write 5 bytes -> full=1 after the 4th write, 5th dropped, overflow=1, level=4; pulse ovf_clr -> overflow=0; release tx_finish -> only the 4 original bytes are launched.
- Simultaneous write+pop at level=2 -> level stays 2, data order preserved.
- Stale finish: transmitter model keeps tx_finish=1 for one cycle after tx_start -> no second tx_start issued.
- Reset mid-frame: assert rst_n=0 during S_BUSY with level=3 -> all outputs to reset values asynchronously; after release, no tx_start without new writes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, frame length and launch FSM encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    localparam int unsigned UART_FRAME_BITS = 10;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_DONE   = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO with registered level/full/empty and a sticky overflow flag.
// head_c presents the current head entry combinationally for the pop side.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  uart_byte_t  wr_data,
    input  logic        pop,
    output uart_byte_t  head_c,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level,
    output logic        overflow,
    input  logic        ovf_clr
);

    uart_byte_t    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   level_nxt;
    logic          wr_accept;
    logic          wr_drop;
    logic          pop_ok;

    // A write into a full FIFO is dropped even if a pop happens in the same cycle.
    assign wr_accept = wr_en & ~full;
    assign wr_drop   = wr_en & full;
    assign pop_ok    = pop & ~empty;
    assign head_c    = mem[rptr];

    // Next occupancy from the accepted write and pop of this cycle.
    always_comb begin
        level_nxt = level;
        unique case ({wr_accept, pop_ok})
            2'b10:   level_nxt = level + (AW+1)'(1);
            2'b01:   level_nxt = level - (AW+1)'(1);
            default: level_nxt = level;
        endcase
    end

    // Storage array; contents are don't-care after reset since level gates them.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wptr] <= wr_data;
        end
    end

    // Pointers, occupancy flags and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            level <= level_nxt;
            full  <= (level_nxt == (AW+1)'(DEPTH));
            empty <= (level_nxt == '0);
            if (wr_drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and launches them one per frame into the serial
// transmitter, keeping the line busy while data is queued.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  uart_byte_t  wr_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level,
    output logic        overflow,
    input  logic        ovf_clr,
    output logic        tx_start,
    output uart_byte_t  tx_data,
    input  logic        tx_finish
);

    tx_state_e  state;
    uart_byte_t head_c;
    logic       pop_c;

    // Pop the head in the same cycle the launch is registered.
    assign pop_c = (state == S_IDLE) & ~empty & tx_finish;

    uart_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .pop      (pop_c),
        .head_c   (head_c),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    // Launch FSM: requires tx_finish to go low then high before the next launch,
    // so a stale idle level right after tx_start cannot trigger a double launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (pop_c) begin
                        tx_start <= 1'b1;
                        tx_data  <= head_c;
                        state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    if (!tx_finish) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (tx_finish) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a behavioural transmitter plus a queue-based model
// of FIFO occupancy, overflow and launch order.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int          NBITS = int'(UART_FRAME_BITS);

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        wr_en     = 1'b0;
    logic [7:0]  wr_data   = 8'h00;
    logic        ovf_clr   = 1'b0;
    logic        tx_finish = 1'b0;
    logic        full;
    logic        empty;
    logic [AW:0] level;
    logic        overflow;
    logic        tx_start;
    logic [7:0]  tx_data;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_finish (tx_finish)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [7:0] q[$];
    logic       ovf_m      = 1'b0;
    logic [7:0] last_data  = 8'h00;
    logic       prev_start = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    bit         seen_low   = 1'b1;
    int         wait_cnt   = 0;
    int         launches   = 0;

    // transmitter model state
    int         bitpos     = -1;
    bit         stale_mode = 1'b0;
    bit         stale_pend = 1'b0;
    bit         hold       = 1'b0;
    logic [7:0] pend_data  = 8'h00;
    logic [9:0] frame      = 10'h3ff;
    logic       line       = 1'b1;
    logic [9:0] cap        = 10'h000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] d);
        frame      = {1'b1, d, 1'b0};
        bitpos     = 0;
        line       = 1'b0;
        cap[0]     = 1'b0;
        tx_finish  = 1'b0;
        stale_pend = 1'b0;
    endtask

    // One clock: update the model from the pre-edge inputs, check outputs, advance the transmitter.
    task automatic step();
        int         cnt_pre;
        bit         launch;
        bit         fin_pre;
        logic [7:0] exp_d;
        @(posedge clk);
        #1;
        fin_pre = tx_finish;
        cnt_pre = q.size();
        launch  = (tx_start === 1'b1);
        if (launch) begin
            chk("no_back_to_back", 32'(prev_start), 32'd0);
            chk("launch_gated_by_finish", 32'(seen_low & fin_pre), 32'd1);
            chk("launch_latency", 32'(wait_cnt <= 3), 32'd1);
            chk("launch_nonempty", 32'(cnt_pre > 0), 32'd1);
            if (cnt_pre > 0) begin
                exp_d = q.pop_front();
                chk("tx_data_order", 32'(tx_data), 32'(exp_d));
                last_data = exp_d;
            end
            seen_low = 1'b0;
            launches++;
        end
        if (wr_en && cnt_pre < int'(DEPTH)) q.push_back(wr_data);
        if (wr_en && cnt_pre >= int'(DEPTH)) ovf_m = 1'b1;
        else if (ovf_clr) ovf_m = 1'b0;

        chk("level", 32'(level), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == int'(DEPTH)));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        if (!launch) chk("tx_data_hold", 32'(tx_data), 32'(last_data));

        if (!fin_pre) seen_low = 1'b1;
        if (launch) wait_cnt = 0;
        else if (q.size() > 0 && bitpos < 0 && !stale_pend && !hold && tx_finish) wait_cnt++;
        else wait_cnt = 0;

        if (bitpos >= 0) begin
            bitpos++;
            if (bitpos >= NBITS) begin
                bitpos = -1;
                line   = 1'b1;
            end else begin
                line        = frame[bitpos];
                cap[bitpos] = line;
                if (!hold) tx_finish = (bitpos == NBITS - 1);
            end
        end else if (stale_pend) begin
            start_frame(pend_data);
        end else if (prev_start && !hold) begin
            if (stale_mode) begin
                stale_pend = 1'b1;
                pend_data  = prev_data;
            end else begin
                start_frame(prev_data);
            end
        end
        prev_start = tx_start;
        prev_data  = tx_data;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() > 0 || bitpos >= 0 || stale_pend || prev_start) && n < 600) begin
            step();
            n++;
        end
        chk("drain_bounded", 32'(n < 600), 32'd1);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        q.delete();
        ovf_m = 1'b0; last_data = 8'h00; prev_start = 1'b0; prev_data = 8'h00;
        seen_low = 1'b1; wait_cnt = 0;
        bitpos = -1; stale_pend = 1'b0; hold = 1'b0; line = 1'b1;
        wr_en = 1'b0; ovf_clr = 1'b0; tx_finish = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        int l0;
        @(posedge clk);
        #1;
        do_reset();
        step();
        step();
        tx_finish = 1'b1;
        step();

        // single byte: latency and serial frame
        write_byte(8'hA5);
        chk("lat_e0_start", 32'(tx_start), 32'd0);
        step();
        chk("lat_e1_start", 32'(tx_start), 32'd1);
        chk("lat_e1_data", 32'(tx_data), 32'hA5);
        step();
        chk("lat_e2_start", 32'(tx_start), 32'd0);
        drain();
        chk("serial_a5", 32'(cap), 32'(10'b1101001010));
        chk("tx_data_after_frame", 32'(tx_data), 32'hA5);

        // back-to-back bytes
        l0 = launches;
        wr_en = 1'b1;
        wr_data = 8'h01; step();
        wr_data = 8'h02; step();
        wr_data = 8'h03; step();
        wr_en = 1'b0;
        drain();
        chk("b2b_launch_count", 32'(launches - l0), 32'd3);

        // overflow with the transmitter held busy
        hold = 1'b1; tx_finish = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            write_byte(8'($urandom));
            if (i == 3) chk("full_after_4", 32'(full), 32'd1);
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd4);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        wr_en = 1'b1; ovf_clr = 1'b1; wr_data = 8'h5A; step();
        wr_en = 1'b0; ovf_clr = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        l0 = launches;
        hold = 1'b0; tx_finish = 1'b1;
        drain();
        chk("ovf_launch_count", 32'(launches - l0), 32'd4);

        // simultaneous write and pop at level 2
        hold = 1'b1; tx_finish = 1'b0;
        step();
        write_byte(8'h11);
        write_byte(8'h22);
        chk("simul_pre_level", 32'(level), 32'd2);
        wr_data = 8'h33; wr_en = 1'b1; hold = 1'b0; tx_finish = 1'b1;
        step();
        wr_en = 1'b0;
        chk("simul_launch", 32'(tx_start), 32'd1);
        chk("simul_level", 32'(level), 32'd2);
        drain();

        // transmitter holds a stale idle level for a cycle after each start
        stale_mode = 1'b1;
        l0 = launches;
        write_byte(8'hC3);
        write_byte(8'h3C);
        write_byte(8'h7E);
        drain();
        chk("stale_launch_count", 32'(launches - l0), 32'd3);
        stale_mode = 1'b0;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            wr_en      = ($urandom_range(0, 9) == 0);
            wr_data    = 8'($urandom);
            ovf_clr    = ($urandom_range(0, 19) == 0);
            stale_mode = 1'($urandom_range(0, 1));
            step();
        end
        wr_en = 1'b0; ovf_clr = 1'b0;
        drain();
        stale_mode = 1'b0;

        // reset in the middle of a frame with bytes queued
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'(8'h40 + i);
            step();
        end
        wr_en = 1'b0;
        chk("midframe_level", 32'(level), 32'd3);
        do_reset();
        step();
        step();
        tx_finish = 1'b1;
        l0 = launches;
        repeat (20) step();
        chk("no_launch_after_reset", 32'(launches - l0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
